// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC ownership, one-outstanding imem handshake, skid FIFO into IF/ID.
// Latency: rvalid in cycle N -> ValidD in N+1 (bypass); StallD holds D, FIFO absorbs, req withheld when full.
// Optional FETCH_PERF_EN adds perf_wait_cnt (saturating stall-cycle counter).

module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_wait_cnt
`endif
);
  localparam int          CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [31:0]   pcf;
  logic [CW-1:0] count;
  logic [63:0]   head_dat;
  logic          empty, accept, d_take, push, pop;

  assign empty     = (count == '0);
  assign imem_req  = (state == REQ) && (count < DEPTH_C);
  assign imem_addr = pcf;

  // Responses are only meaningful while one is owed and not redirected away.
  assign accept = (state == WAIT) && imem_rvalid && !PCSrcE;
  assign d_take = !StallD && !PCSrcE;
  assign pop    = d_take && !empty;
  assign push   = accept && !(d_take && empty);

  fetch_fifo #(.W(64), .DEPTH(BUF_DEPTH), .CW(CW)) u_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (PCSrcE),
    .push     (push),
    .push_dat ({pcf, imem_rdata}),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (imem_req && imem_gnt) state_nxt = PCSrcE ? DISCARD : WAIT;
      WAIT: begin
        if (imem_rvalid)  state_nxt = REQ;
        else if (PCSrcE)  state_nxt = DISCARD;
      end
      DISCARD: if (imem_rvalid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pcf   <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (PCSrcE)      pcf <= PCTargetE & ~32'd3;
      else if (accept) pcf <= pcf + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ValidD   <= 1'b0;
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (PCSrcE) begin
      ValidD <= 1'b0;
      InstrD <= NOP;
    end else if (!StallD) begin
      if (!empty) begin
        ValidD   <= 1'b1;
        PCD      <= head_dat[63:32];
        PCPlus4D <= head_dat[63:32] + 32'd4;
        InstrD   <= head_dat[31:0];
      end else if (accept) begin
        ValidD   <= 1'b1;
        PCD      <= pcf;
        PCPlus4D <= pcf + 32'd4;
        InstrD   <= imem_rdata;
      end else begin
        ValidD <= 1'b0;
        InstrD <= NOP;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic waiting;
  assign waiting = (state == WAIT) || (state == DISCARD) || (imem_req && !imem_gnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       perf_wait_cnt <= '0;
    else if (waiting && (perf_wait_cnt != '1))       perf_wait_cnt <= perf_wait_cnt + 32'd1;
  end
`endif
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage.
- Owns the fetch PC and issues one-outstanding requests to a variable-latency instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small skid FIFO and drives the IF/ID outputs.
- Handles decode stalls (StallD) and execute-stage redirects (PCSrcE/PCTargetE), including squashing in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- BUF_DEPTH, 2, skid FIFO entries (power of two, >=2).

Ports:
- clk, input, 1, the single clock; all state on rising edge.
- reset, input, 1, asynchronous active-high reset.
- StallD, input, 1, decode cannot accept; D outputs hold.
- PCSrcE, input, 1, redirect request from execute.
- PCTargetE, input, 32, redirect target; bits [1:0] ignored (forced 0).
- imem_req, output, 1, request valid.
- imem_addr, output, 32, request address (= PCF).
- imem_gnt, input, 1, memory accepted request this cycle.
- imem_rvalid, input, 1, response data valid.
- imem_rdata, input, 32, response instruction.
- InstrD, output, 32, instruction to decode.
- PCD, output, 32, PC of InstrD.
- PCPlus4D, output, 32, PCD+4 (mod 2^32).
- ValidD, output, 1, D outputs hold a real instruction.

Behaviour:
- Reset values: PCF=RESET_PC, state=IDLE, FIFO count=0, imem_req=0, ValidD=0, InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0.
- FSM states:
  - IDLE: always moves to REQ on the first edge after reset deasserts.
  - REQ: imem_req=1 only when count < BUF_DEPTH. On gnt, go to WAIT. With no gnt, stay; address is held stable while req=1.
  - WAIT: imem_req=0. On rvalid, push {PCF, rdata} and set PCF<=PCF+4, then go to REQ.
  - DISCARD: imem_req=0. The next rvalid is dropped, then go to REQ.
- Redirect (PCSrcE=1, any state):
  - PCF<=PCTargetE & ~3.
  - FIFO is flushed (count=0).
  - Next edge: ValidD=0, InstrD=NOP, regardless of StallD.
- Redirect in WAIT:
  - Without rvalid the same cycle: go to DISCARD.
  - With rvalid the same cycle: data is dropped; go to REQ.
- Redirect in REQ:
  - With gnt the same cycle: go to DISCARD.
  - Without gnt: stay in REQ; the next cycle's address is the new target.
- Redirect in DISCARD: stay in DISCARD (still one response owed). If rvalid arrives the same cycle, go to REQ.
- Wrap-around: PCF+4 and PCPlus4D wrap modulo 2^32 with no flag.
- D register update when !StallD && !PCSrcE:
  - FIFO non-empty: pop head into D; ValidD=1.
  - FIFO empty but rvalid is being accepted (WAIT, no redirect): bypass rdata/PCF directly into D; ValidD=1. Latency is rvalid at cycle N -> ValidD at N+1.
  - Otherwise: ValidD=0, InstrD=NOP.
- StallD=1 without redirect: D holds; responses still push into the FIFO; REQ withholds req when the FIFO is full.
- Simultaneous push and pop: count unchanged; order preserved.
- Reset mid-transaction: all state returns to reset values immediately. Any late rvalid is ignored while in IDLE or REQ (a response arriving outside WAIT/DISCARD is dropped).

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds output perf_wait_cnt[31:0]. It increments each cycle the FSM is in WAIT or DISCARD, or in REQ with req=1 and no gnt. It saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then zero-wait memory (gnt in REQ, rvalid next cycle, RESET_PC=0) -> imem_addr 0,4,8; D outputs show PCD=0, PCPlus4D=4, ValidD=1, one instruction every 2 cycles.
- StallD=1 for 6 cycles with a fast memory -> FIFO fills to 2, imem_req drops to 0, D holds the first instruction. On release, PCD steps 0,4,8 in consecutive cycles with no gap or duplicate.
- PCSrcE=1, PCTargetE=32'h0000_0103 while in WAIT -> next rvalid is dropped, next imem_addr=32'h100, ValidD=0 for at least one cycle, next valid PCD=32'h100.
- PCSrcE=1 coincident with gnt in REQ -> state DISCARD; the stale response is dropped; PCD for the next valid instruction equals the target.
- PCF=32'hFFFF_FFFC fetched -> PCPlus4D=0 and the next imem_addr=0.
- reset asserted in WAIT -> same cycle imem_req=0, ValidD=0, InstrD=32'h13; a stale rvalid afterward has no effect. With FETCH_PERF_EN, perf_wait_cnt=0.
